uart_tx_ext: RTL
================

UART_TX_EXT -- requirements
Module: uart_tx_ext

Interface
REQ-001 Clock is clk; reset is reset, asynchronous and active-low; single clock domain.
REQ-002 Parameter DBIT_MAX, default 8, is the maximum data bits per frame; legal range 5..9.
REQ-003 Parameter OS, default 16, is the baud_tick count per bit period; legal range 4..32.
REQ-004 Ports SHALL be exactly as listed:
  clk          in   1         system clock
  reset        in   1         async active-low reset
  baud_tick    in   1         single-cycle oversample strobe
  cfg_dbits    in   4         data bits per frame, 5..DBIT_MAX
  cfg_parity   in   2         00 none, 01 even, 10 odd, 11 none
  cfg_stop2    in   1         0 = one stop bit, 1 = two stop bits
  tx_valid     in   1         frame request
  tx_data      in   DBIT_MAX  frame payload, LSB first
  tx_ready     out  1         high only in IDLE
  tx_busy      out  1         high in any state other than IDLE
  tx_done_tick out  1         one-clk pulse at frame end
  tx           out  1         serial line, registered, idle high

Function
REQ-005 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-006 Acceptance SHALL occur on the rising clk edge where tx_valid and tx_ready are both high.
REQ-007 On acceptance: tx_data and all cfg_* SHALL be latched; START entered; tx low from that edge; bit-tick counter and bit index cleared.
REQ-008 cfg_* and tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-009 cfg_dbits below 5 SHALL be treated as 5; above DBIT_MAX as DBIT_MAX; payload bits at or above the effective length SHALL be ignored.
REQ-010 Every bit period (start, data, parity, stop) SHALL end on the clk edge that samples the OS-th baud_tick of that bit; the state/bit change SHALL occur on that same edge.
REQ-011 DATA SHALL drive payload bits LSB first, one per bit period, for exactly the effective length.
REQ-012 PARITY SHALL be skipped when parity is none; even = XOR of transmitted data bits; odd = inverse of that value.
REQ-013 STOP SHALL drive tx high for OS baud_ticks, or 2*OS baud_ticks when cfg_stop2 was latched as 1.
REQ-014 At the end of STOP: tx_done_tick SHALL pulse for exactly one clk and the state SHALL return to IDLE.
REQ-015 In IDLE: tx SHALL be high and baud_tick ignored. The earliest next acceptance is the edge following the return to IDLE; the gap between frames is therefore at least the stop period plus one clk.
REQ-016 baud_tick asserted on consecutive clks SHALL count once per clk; no ticks are lost or merged.
REQ-017 tx_ready and tx_busy SHALL be complementary, decoded from the registered state; no combinational path from tx_valid.
REQ-018 Counter widths: tick counter clog2(2*OS+1); bit index clog2(DBIT_MAX+1); no wrap inside a frame.

Reset
REQ-019 reset low SHALL force IDLE, tx = 1, tx_done_tick = 0, tx_ready = 1, tx_busy = 0, and clear all counters and latched data, including mid-frame.
REQ-020 A frame aborted by reset SHALL NOT produce tx_done_tick.

Structure
REQ-021 Package uart_pkg SHALL hold the state enum, the parity-mode encoding, and the DBIT_MIN=5 constant.
REQ-022 A single sub-module, uart_bit_timer, SHALL count baud_ticks to a programmable limit (OS or 2*OS) and emit bit_end; all other logic stays in uart_tx_ext.

Verification
REQ-023 Run each scenario with baud_tick every clk and again with baud_tick every 4th clk. Check tx at mid-bit of each bit period against the values below.
REQ-024 8N1, tx_data=0x55, OS=16:
  - tx = 0,1,0,1,0,1,0,1,0,1.
  - 160 ticks from acceptance to tx_done_tick.
  - tx_ready stays low throughout.
REQ-025 7E1, tx_data=0xC1:
  - Bit 7 ignored; data bits 1,0,0,0,0,0,1; parity 0.
  - Frame is 10 bit periods.
REQ-026 5O2, tx_data=0x1F:
  - Data bits all 1, parity 0.
  - Stop high for 32 ticks; done pulse exactly one clk.
REQ-027 tx_valid held high with 0xA5 then 0x3C, 8N1:
  - Second acceptance on the first IDLE edge after done.
  - Second frame bits are 0x3C LSB first.
  - cfg changes mid-frame have no effect.
REQ-028 reset asserted during DATA bit 3:
  - tx high immediately, no tx_done_tick.
  - Next 8N1 frame after release is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART transmitter.
package uart_pkg;

  // Smallest frame payload the transmitter will send; shorter requests are padded up to this.
  localparam int DBIT_MIN = 5;

  // Transmitter frame phases.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity selection as presented on cfg_parity; code 11 behaves like no parity.
  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample strobes within one bit period and flags the strobe that closes it.
module uart_bit_timer #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          baud_tick_i,
  input  logic [CW-1:0] limit_i,
  output logic          bit_end_o
);

  logic [CW-1:0] cnt_q;

  // The period closes on the strobe that brings the count up to the limit.
  assign bit_end_o = run_i & baud_tick_i & (cnt_q == (limit_i - CW'(1)));

  // Strobe counter: held at zero while idle, restarts at every period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!run_i) begin
      cnt_q <= '0;
    end else if (baud_tick_i) begin
      cnt_q <= bit_end_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with runtime frame length, parity and stop-bit selection.
module uart_tx_ext #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                baud_tick,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  input  logic                tx_valid,
  input  logic [DBIT_MAX-1:0] tx_data,
  output logic                tx_ready,
  output logic                tx_busy,
  output logic                tx_done_tick,
  output logic                tx
);

  import uart_pkg::*;

  localparam int CW = $clog2(2*OS+1);
  localparam int BW = $clog2(DBIT_MAX+1);

  tx_state_e           state_q;
  logic                tx_q;
  logic                done_q;
  logic [DBIT_MAX-1:0] shift_q;
  logic [BW-1:0]       bitIdx_q;
  logic [BW-1:0]       lastIdx_q;
  logic [BW-1:0]       lastIdx_d;
  parity_e             parMode_q;
  logic                stop2_q;
  logic                par_q;
  logic [3:0]          effDbits;
  logic [CW-1:0]       tickLimit;
  logic                timerRun;
  logic                bitEnd;

  // Clamp the requested payload length into the supported range and turn it into a last-bit index.
  always_comb begin
    effDbits = cfg_dbits;
    if (cfg_dbits < 4'(DBIT_MIN)) begin
      effDbits = 4'(DBIT_MIN);
    end else if (cfg_dbits > 4'(DBIT_MAX)) begin
      effDbits = 4'(DBIT_MAX);
    end
    lastIdx_d = BW'(effDbits - 4'd1);
  end

  assign timerRun  = (state_q != IDLE);
  assign tickLimit = ((state_q == STOP) && stop2_q) ? CW'(2*OS) : CW'(OS);

  uart_bit_timer #(.CW(CW)) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .run_i       (timerRun),
    .baud_tick_i (baud_tick),
    .limit_i     (tickLimit),
    .bit_end_o   (bitEnd)
  );

  // Frame sequencer: latches the request, walks the frame bits and drives the registered line and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      lastIdx_q <= '0;
      parMode_q <= PAR_NONE;
      stop2_q   <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            shift_q   <= tx_data;
            lastIdx_q <= lastIdx_d;
            parMode_q <= parity_e'(cfg_parity);
            stop2_q   <= cfg_stop2;
            bitIdx_q  <= '0;
            par_q     <= 1'b0;
          end
        end
        START: begin
          if (bitEnd) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bitEnd) begin
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            if (bitIdx_q == lastIdx_q) begin
              if (parMode_q == PAR_EVEN) begin
                state_q <= PARITY;
                tx_q    <= par_q ^ shift_q[0];
              end else if (parMode_q == PAR_ODD) begin
                state_q <= PARITY;
                tx_q    <= ~(par_q ^ shift_q[0]);
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bitIdx_q <= bitIdx_q + BW'(1);
              tx_q     <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bitEnd) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bitEnd) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_ready     = (state_q == IDLE);
  assign tx_busy      = ~tx_ready;

endmodule
